// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one subtract/compare ALU between two requesters
module cmp_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp0_taken,
    output logic             resp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic             resp1_taken,
    output logic             resp1_err,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic             cmp_eql,
    input  logic             cmp_slt,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       rr;
    logic       gnt;
    logic [1:0] op_q;
    logic [7:0] cnt;
    logic       resp_hs;
    logic       cond;

    // rr = 0 favours port 0 when both request in the same cycle
    assign req0_ready = (state == S_IDLE) && req0_valid && (!req1_valid || !rr);
    assign req1_ready = (state == S_IDLE) && req1_valid && (!req0_valid || rr);

    assign resp_hs = gnt ? resp1_ready : resp0_ready;

    always_comb begin
        cond = 1'b0;
        case (op_q)
            2'b00:   cond = cmp_eql;
            2'b01:   cond = !cmp_eql;
            2'b10:   cond = cmp_slt;
            default: cond = !alu_cout;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr          <= 1'b0;
            gnt         <= 1'b0;
            op_q        <= 2'b00;
            cnt         <= 8'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sub     <= 1'b0;
            alu_start   <= 1'b0;
            resp0_valid <= 1'b0;
            resp0_taken <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_taken <= 1'b0;
            resp1_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        gnt       <= req1_ready;
                        alu_a     <= req1_ready ? req1_a  : req0_a;
                        alu_b     <= req1_ready ? req1_b  : req0_b;
                        op_q      <= req1_ready ? req1_op : req0_op;
                        alu_start <= 1'b1;
                        alu_sub   <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_start <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        alu_sub     <= 1'b0;
                        resp0_valid <= !gnt;
                        resp0_taken <= !gnt && cond;
                        resp0_err   <= 1'b0;
                        resp1_valid <= gnt;
                        resp1_taken <= gnt && cond;
                        resp1_err   <= 1'b0;
                        state       <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        // ALU never answered: report not-taken with error
                        alu_sub     <= 1'b0;
                        resp0_valid <= !gnt;
                        resp0_taken <= 1'b0;
                        resp0_err   <= !gnt;
                        resp1_valid <= gnt;
                        resp1_taken <= 1'b0;
                        resp1_err   <= gnt;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_hs) begin
                        resp0_valid <= 1'b0;
                        resp0_taken <= 1'b0;
                        resp0_err   <= 1'b0;
                        resp1_valid <= 1'b0;
                        resp1_taken <= 1'b0;
                        resp1_err   <= 1'b0;
                        rr          <= !gnt;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - randomized self-checking bench for cmp_arbiter with a behavioural ALU and reference model
module tb_cmp_arbiter;
    localparam int W  = 32;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic         resp0_valid, resp0_taken, resp0_err;
    logic         resp1_valid, resp1_taken, resp1_err;
    logic         resp0_ready = 0, resp1_ready = 0;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_sub, alu_start;
    logic         alu_done = 0, cmp_eql = 0, cmp_slt = 0, alu_cout = 0;

    cmp_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_taken(resp0_taken), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_taken(resp1_taken), .resp1_err(resp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_start(alu_start),
        .alu_done(alu_done), .cmp_eql(cmp_eql), .cmp_slt(cmp_slt), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit rr_m  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand(input int mode);
        if (mode == 1) return W'($signed($urandom_range(0, 8)) - 4);
        return W'($urandom);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {req0_ready, req1_ready, resp0_valid, resp0_taken, resp0_err,
                              resp1_valid, resp1_taken, resp1_err, alu_sub, alu_start}, 10'd0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
    endtask

    // One arbitration round: present requests, play the ALU, consume the response
    task automatic round(input bit v0, input bit v1, input int delay, input bit to, input int hold);
        logic [W-1:0] a[2], b[2];
        logic [1:0]   op[2];
        logic [W-1:0] ea, eb;
        logic         et, tk, er;
        int           win, n, mode, exp_lat;
        bit           seen;
        for (int p = 0; p < 2; p++) begin
            mode = int'($urandom_range(0, 3));
            a[p]  = pick_operand(mode);
            b[p]  = (mode == 0) ? a[p] : pick_operand(mode);
            op[p] = 2'($urandom);
        end
        win = (v0 && v1) ? int'(rr_m) : (v0 ? 0 : 1);
        ea = a[win];
        eb = b[win];
        et = ref_taken(op[win], ea, eb);

        @(negedge clk);
        req0_valid = v0; req0_a = a[0]; req0_b = b[0]; req0_op = op[0];
        req1_valid = v1; req1_a = a[1]; req1_b = b[1]; req1_op = op[1];
        resp0_ready = (hold == 0);
        resp1_ready = (hold == 0);
        #1;
        check("grant0", req0_ready, win == 0);
        check("grant1", req1_ready, win == 1);

        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            alu_done = 0;
            if (win == 0 ? resp0_valid : resp1_valid) begin
                seen = 1;
            end else begin
                check("alu_start", alu_start, n == 1);
                check("alu_sub", alu_sub, 1);
                check("alu_a", alu_a, ea);
                check("alu_b", alu_b, eb);
                if (n == 1) begin
                    // accepted operands must be immune to later changes
                    if (win == 0) begin req0_valid = 0; req0_a = ~ea; req0_b = W'($urandom); end
                    else          begin req1_valid = 0; req1_a = ~ea; req1_b = W'($urandom); end
                    alu_done = 1'($urandom);
                    cmp_eql = 1'($urandom); cmp_slt = 1'($urandom); alu_cout = 1'($urandom);
                end else if (!to && n == 2 + delay) begin
                    alu_done = 1;
                    cmp_eql  = (ea == eb);
                    cmp_slt  = $signed(ea) < $signed(eb);
                    alu_cout = (ea >= eb);
                end
            end
            check("other_resp", win == 0 ? resp1_valid : resp0_valid, 0);
            check("busy_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        alu_done = 0;
        check("resp_seen", seen, 1);
        exp_lat = to ? 2 + TO : 3 + delay;
        check("latency", n, exp_lat);
        tk = (win == 0) ? resp0_taken : resp1_taken;
        er = (win == 0) ? resp0_err : resp1_err;
        check("taken", tk, to ? 1'b0 : et);
        check("err", er, to);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", win == 0 ? resp0_valid : resp1_valid, 1);
            check("hold_taken", win == 0 ? resp0_taken : resp1_taken, tk);
            check("hold_err", win == 0 ? resp0_err : resp1_err, er);
        end
        resp0_ready = 1;
        resp1_ready = 1;
        @(negedge clk);
        check("resp_drop", {resp0_valid, resp0_taken, resp0_err, resp1_valid, resp1_taken, resp1_err}, 6'd0);
        if (v0 && v1) check("loser_pending", win == 0 ? req1_ready : req0_ready, 1);
        rr_m = (win == 0);
        req0_valid = 0;
        req1_valid = 0;
        resp0_ready = 0;
        resp1_ready = 0;
    endtask

    initial begin
        int pat;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;

        @(negedge clk);
        req0_valid = 1; req0_a = 5; req0_b = 5; req0_op = 2'd0;
        #1;
        check("rst_test_rdy", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1;
        repeat (6) begin
            @(negedge clk);
            check("no_resp_after_rst", {resp0_valid, resp1_valid, alu_start}, 3'd0);
        end
        rr_m = 0;

        round(1, 0, 0, 0, 3);
        round(1, 1, 0, 0, 0);
        round(1, 1, 1, 0, 1);
        round(1, 1, 0, 0, 2);
        round(0, 1, 2, 0, 0);
        round(1, 0, 0, 1, 1);
        round(1, 0, 0, 0, 0);
        for (int r = 0; r < 70; r++) begin
            pat = int'($urandom_range(1, 3));
            round(pat[0], pat[1], int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
Shares the single subtract ALU and its comparer (eql/slt flags) between two requesters, e.g. the branch unit (port 0) and the set-less-than path (port 1). Round-robin arbitration; a 4-state FSM issues one compare at a time, waits for ALU completion with a timeout, decodes the branch condition from the flags, and returns the result over a valid/ready response handshake.

Parameters:
WIDTH, 32, operand width in bits
TIMEOUT, 15, max cycles in WAIT before an error response (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a compare pending
req0_ready  output  1  one-cycle accept pulse to requester 0
req0_a  input  WIDTH  operand A, requester 0
req0_b  input  WIDTH  operand B, requester 0
req0_op  input  2  00 EQ, 01 NE, 10 LT signed, 11 LTU
resp0_valid  output  1  result available for requester 0
resp0_ready  input  1  requester 0 consumes result
resp0_taken  output  1  condition true
resp0_err  output  1  ALU timed out
req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready, resp1_taken, resp1_err  same as port 0, requester 1
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_sub  output  1  subtract select, 1 while ISSUE/WAIT
alu_start  output  1  one-cycle start pulse
alu_done  input  1  ALU result and flags valid this cycle
cmp_eql  input  1  comparer equal flag
cmp_slt  input  1  comparer signed less-than flag
alu_cout  input  1  carry out of A-B (1 = no borrow)

Behaviour:
- Reset (rst_n low, async): state IDLE, rr pointer 0 (req0 favoured), timeout counter 0; every output 0 incl. alu_a/alu_b. In-flight op discarded, no response.
- IDLE: if exactly one reqN_valid, grant it; both valid -> grant rr-favoured port. Winner's reqN_ready = 1 that cycle (combinational from valid+state); latch a, b, op, grant id; -> ISSUE. Loser's ready stays 0 and it stays pending.
- ISSUE (1 cycle): alu_start = 1, alu_sub = 1, alu_a/alu_b = latched operands; clear counter; -> WAIT. alu_done in ISSUE ignored.
- WAIT: alu_a/alu_b/alu_sub held, alu_start = 0. On alu_done: register cmp_eql, cmp_slt, alu_cout; taken = EQ: eql; NE: !eql; LT: slt; LTU: !cout; err = 0; -> RESP. Otherwise counter++; counter reaching TIMEOUT with no done -> taken = 0, err = 1, -> RESP.
- RESP: respN_valid = 1 for granted port only, taken/err stable until respN_ready high at a clock edge; then rr pointer = other port, -> IDLE. resp_ready high before valid is legal. Other port's resp outputs stay 0.
- Minimum latency: accept at edge T, start in cycle T+1, done earliest T+2, respN_valid from T+3. Back-to-back: next accept no earlier than cycle after response handshake.
- Operands sampled only on the accept edge; later changes on reqN_a/b have no effect.
- Outputs other than reqN_ready are registered.

Test Plan:
- Reset mid-WAIT (req0 accepted, rst_n low before done) -> all outputs 0 immediately, no resp0_valid after release, next req0 served normally.
- req0 EQ a=5 b=5, alu_done 1 cycle after start with eql=1 -> resp0_valid at T+3, taken=1, err=0; held 3 cycles until resp0_ready, then drops.
- Both valid in IDLE after reset: req0 LT a=-3 b=2 (slt=1), req1 LTU a=1 b=0xFFFFFFFF (cout=0) -> req0 served first taken=1; req1 then served, taken=1; third simultaneous pair -> req0 granted again (rr alternates).
- req1 NE a=7 b=7 (eql=1) -> resp1_taken=0; resp0_valid never asserts.
- alu_done never asserted, TIMEOUT=15 -> resp0_valid with taken=0, err=1 after 15 WAIT cycles; next request completes with err=0.
- Operands changed on req0_a the cycle after accept -> alu_a keeps accepted value through WAIT.
